// File: rtl/dnd_mem_pkg.sv
// Shared constants, the stored timestamp/polarity word and the arbiter FSM states
// for the timestamp memory arbiter.
package dnd_mem_pkg;

    localparam int DVS_WIDTH_DEF       = 346;
    localparam int DVS_HEIGHT_DEF      = 260;
    localparam int WORD_SIZE_DEF       = 18;
    localparam int CAVIAR_X_Y_BITS_DEF = 9;
    localparam int TIMESTAMP_BITS_DEF  = 16;
    localparam int POLARITY_BITS_DEF   = 2;

    typedef struct packed {
        logic [TIMESTAMP_BITS_DEF-1:0] ts;
        logic [POLARITY_BITS_DEF-1:0]  pol;
    } ts_word_t;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        ISSUE_RD,
        ISSUE_WR
    } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: remembers whether the writer was granted last and
// flags cycles in which both requesters compete.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic rd_req,
    input  logic wr_req,
    input  logic take_rd,
    input  logic take_wr,
    output logic pick_wr,
    output logic contention
);

    logic last_wr_reg;

    // On a tie the requester that did not win last time goes first.
    assign pick_wr    = wr_req & (~rd_req | ~last_wr_reg);
    assign contention = en & rd_req & wr_req;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_wr_reg <= 1'b0;
        end else if (take_wr) begin
            last_wr_reg <= 1'b1;
        end else if (take_rd) begin
            last_wr_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/ts_mem_arbiter.sv
// Arbitrates the timestamp/polarity memory between the event writer and the patch
// reader. Define TS_MEM_INIT_EN to clear the whole memory after reset.
module ts_mem_arbiter
    import dnd_mem_pkg::*;
#(
    parameter int DVS_WIDTH       = DVS_WIDTH_DEF,
    parameter int DVS_HEIGHT      = DVS_HEIGHT_DEF,
    parameter int WORD_SIZE       = WORD_SIZE_DEF,
    parameter int CAVIAR_X_Y_BITS = CAVIAR_X_Y_BITS_DEF,
    parameter int TIMESTAMP_BITS  = TIMESTAMP_BITS_DEF,
    parameter int POLARITY_BITS   = POLARITY_BITS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rd_req,
    input  logic [CAVIAR_X_Y_BITS-1:0] rd_x1,
    input  logic [CAVIAR_X_Y_BITS-1:0] rd_y1,
    input  logic [CAVIAR_X_Y_BITS-1:0] rd_x2,
    input  logic [CAVIAR_X_Y_BITS-1:0] rd_y2,
    output logic                       rd_gnt,
    output logic [WORD_SIZE-1:0]       rd_data1,
    output logic [WORD_SIZE-1:0]       rd_data2,
    output logic                       rd_vld,
    input  logic                       wr_req,
    input  logic [CAVIAR_X_Y_BITS-1:0] wr_x,
    input  logic [CAVIAR_X_Y_BITS-1:0] wr_y,
    input  logic [TIMESTAMP_BITS-1:0]  wr_ts,
    input  logic [POLARITY_BITS-1:0]   wr_pol,
    output logic                       wr_gnt,
    output logic                       mem_cen,
    output logic                       mem_rw,
    output logic [CAVIAR_X_Y_BITS-1:0] mem_addr1_x,
    output logic [CAVIAR_X_Y_BITS-1:0] mem_addr1_y,
    output logic [CAVIAR_X_Y_BITS-1:0] mem_addr2_x,
    output logic [CAVIAR_X_Y_BITS-1:0] mem_addr2_y,
    output logic [WORD_SIZE-1:0]       mem_wdata,
    input  logic [WORD_SIZE-1:0]       mem_rdata1,
    input  logic [WORD_SIZE-1:0]       mem_rdata2,
    input  logic                       mem_rvld1,
    input  logic                       mem_rvld2,
    output logic                       init_busy,
    output logic [15:0]                conflict_cnt
);

    if (WORD_SIZE != TIMESTAMP_BITS + POLARITY_BITS ||
        DVS_WIDTH > (1 << CAVIAR_X_Y_BITS) || DVS_HEIGHT > (1 << CAVIAR_X_Y_BITS)) begin : g_bad_cfg
        $error("ts_mem_arbiter: inconsistent word or coordinate widths");
    end

`ifdef TS_MEM_INIT_EN
    localparam arb_state_t RESET_STATE = INIT;
    logic [CAVIAR_X_Y_BITS-1:0] init_x_reg;
    logic [CAVIAR_X_Y_BITS-1:0] init_y_reg;
`else
    localparam arb_state_t RESET_STATE = IDLE;
    assign init_busy = 1'b0;
`endif

    arb_state_t state_reg;
    logic       pend_rd_reg;
    logic       go_rd;
    logic       go_wr;
    logic       pick_wr;
    logic       contention;
    ts_word_t   wr_word;

    assign wr_word  = '{ts: wr_ts, pol: wr_pol};
    assign rd_vld   = pend_rd_reg & mem_rvld1 & mem_rvld2;
    assign rd_data1 = mem_rdata1;
    assign rd_data2 = mem_rdata2;

    rr_arb2 u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (state_reg != INIT),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .take_rd    (go_rd),
        .take_wr    (go_wr),
        .pick_wr    (pick_wr),
        .contention (contention)
    );

    // The requester granted this cycle is ignored; only the other one can chain in.
    always_comb begin
        go_rd = 1'b0;
        go_wr = 1'b0;
        case (state_reg)
            IDLE: begin
                go_wr = pick_wr;
                go_rd = rd_req & ~pick_wr;
            end
            ISSUE_RD: go_wr = wr_req;
            ISSUE_WR: go_rd = rd_req;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= RESET_STATE;
            rd_gnt       <= 1'b0;
            wr_gnt       <= 1'b0;
            mem_cen      <= 1'b0;
            mem_rw       <= 1'b0;
            mem_addr1_x  <= '0;
            mem_addr1_y  <= '0;
            mem_addr2_x  <= '0;
            mem_addr2_y  <= '0;
            mem_wdata    <= '0;
            pend_rd_reg  <= 1'b0;
            conflict_cnt <= '0;
`ifdef TS_MEM_INIT_EN
            init_busy    <= 1'b1;
            init_x_reg   <= '0;
            init_y_reg   <= '0;
`endif
        end else begin
            rd_gnt  <= go_rd;
            wr_gnt  <= go_wr;
            mem_cen <= go_rd | go_wr;
            mem_rw  <= go_wr;
            if (go_rd) begin
                state_reg   <= ISSUE_RD;
                mem_addr1_x <= rd_x1;
                mem_addr1_y <= rd_y1;
                mem_addr2_x <= rd_x2;
                mem_addr2_y <= rd_y2;
            end else if (go_wr) begin
                state_reg   <= ISSUE_WR;
                mem_addr1_x <= wr_x;
                mem_addr1_y <= wr_y;
                mem_wdata   <= WORD_SIZE'(wr_word);
`ifdef TS_MEM_INIT_EN
            end else if (state_reg == INIT) begin
                // Column-major sweep: y runs fastest, one zero word per cycle.
                mem_cen     <= 1'b1;
                mem_rw      <= 1'b1;
                mem_addr1_x <= init_x_reg;
                mem_addr1_y <= init_y_reg;
                mem_wdata   <= '0;
                if (init_y_reg == CAVIAR_X_Y_BITS'(DVS_HEIGHT - 1)) begin
                    init_y_reg <= '0;
                    if (init_x_reg == CAVIAR_X_Y_BITS'(DVS_WIDTH - 1)) begin
                        state_reg <= IDLE;
                        init_busy <= 1'b0;
                    end else begin
                        init_x_reg <= init_x_reg + 1'b1;
                    end
                end else begin
                    init_y_reg <= init_y_reg + 1'b1;
                end
`endif
            end else begin
                state_reg <= IDLE;
            end

            // Armed after the read command so stale read-valids cannot complete it.
            if (state_reg == ISSUE_RD) begin
                pend_rd_reg <= 1'b1;
            end else if (rd_vld) begin
                pend_rd_reg <= 1'b0;
            end

            if (contention && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/ts_mem_arbiter.md
# ts_mem_arbiter

Shares the single timestamp/polarity memory between the event writer, which stores `{timestamp, polarity}` at each incoming CAVIAR event's pixel, and `create_mlp_activations`, which issues dual-port patch reads. It sits between both requesters and the memory's `cen`/`rw`/dual-address interface. It arbitrates round-robin with a req/gnt handshake, routes read data back to the reader, and optionally clears the memory after reset.

## Interface
- `DVS_WIDTH`, 346, sensor columns (x range)
- `DVS_HEIGHT`, 260, sensor rows (y range)
- `WORD_SIZE`, 18, memory word width; must equal `TIMESTAMP_BITS + POLARITY_BITS`
- `CAVIAR_X_Y_BITS`, 9, coordinate width
- `TIMESTAMP_BITS`, 16, timestamp field
- `POLARITY_BITS`, 2, polarity field
- `clk` in 1: single clock, all logic on the rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `rd_req` in 1: reader request; held until `rd_gnt`
- `rd_x1`, `rd_y1`, `rd_x2`, `rd_y2` in `CAVIAR_X_Y_BITS` each: reader port-1 and port-2 addresses; stable while `rd_req` is high
- `rd_gnt` out 1: one-cycle grant pulse to the reader
- `rd_data1`, `rd_data2` out `WORD_SIZE`: read data returned to the reader
- `rd_vld` out 1: `rd_data1`/`rd_data2` valid
- `wr_req` in 1: writer request; held until `wr_gnt`
- `wr_x`, `wr_y` in `CAVIAR_X_Y_BITS`: write address
- `wr_ts` in `TIMESTAMP_BITS`: timestamp to store
- `wr_pol` in `POLARITY_BITS`: polarity to store
- `wr_gnt` out 1: one-cycle grant pulse to the writer
- `mem_cen` out 1: memory enable
- `mem_rw` out 1: 1 = write, 0 = read
- `mem_addr1_x`, `mem_addr1_y`, `mem_addr2_x`, `mem_addr2_y` out `CAVIAR_X_Y_BITS`: memory addresses
- `mem_wdata` out `WORD_SIZE`: write word `{ts, pol}`, ts in the MSBs
- `mem_rdata1`, `mem_rdata2` in `WORD_SIZE`: memory read data
- `mem_rvld1`, `mem_rvld2` in 1: memory read-valid flags, one cycle after a read
- `init_busy` out 1: clear sweep in progress
- `conflict_cnt` out 16: saturating count of contention cycles

## Operation
- FSM states: `INIT`, `IDLE`, `ISSUE_RD`, `ISSUE_WR`.
- Reset target is `INIT` when the clear feature is compiled in, otherwise `IDLE`.
- `IDLE` samples requests at the clock edge:
  - Only `rd_req` high: go to `ISSUE_RD`.
  - Only `wr_req` high: go to `ISSUE_WR`.
  - Both high: grant the requester that was not granted last (`last_wr` flag, reset value 0, so the writer wins the first tie). Increment `conflict_cnt`, saturating at 16'hFFFF.
- `ISSUE_RD` lasts one cycle:
  - Drive `mem_cen`=1, `mem_rw`=0, both address pairs from the registered `rd_*` operands.
  - Assert `rd_gnt`=1, set `pend_rd`, clear `last_wr`.
- `ISSUE_WR` lasts one cycle:
  - Drive `mem_cen`=1, `mem_rw`=1, port-1 address = `wr_x`/`wr_y`, `mem_wdata` = `{wr_ts, wr_pol}`.
  - Assert `wr_gnt`=1, set `last_wr`.
- From either issue state:
  - If the other requester's `req` is high, go directly to the other issue state.
  - Otherwise return to `IDLE`.
  - The just-granted requester's `req` is ignored in its grant cycle.
- Read return: `rd_vld = pend_rd & mem_rvld1 & mem_rvld2`. `rd_data1`/`rd_data2` pass through from `mem_rdata1`/`mem_rdata2`. `pend_rd` clears when `rd_vld` fires.
- Coordinates are not range-checked; the requesters guarantee x < `DVS_WIDTH` and y < `DVS_HEIGHT`.

## Timing
- Reset values: all grants 0, `mem_cen` 0, `mem_rw` 0, all addresses 0, `mem_wdata` 0, `rd_vld` 0, `conflict_cnt` 0. `init_busy` is 1 if the clear feature is compiled in, else 0.
- Outputs are registered, except `rd_vld`/`rd_data*`, which are combinational pass-through.
- Read path: `rd_req` sampled at edge N; `rd_gnt` and the memory command during cycle N+1; `rd_vld` during N+2.
- Write path: `wr_gnt` during N+1; memory updated at the end of N+1.
- Read-after-write to the same pixel issued in the next cycle returns the new word; no forwarding is needed.
- Throughput: one memory access per cycle under alternating contention; a single requester gets at most one grant every 2 cycles.
- `rst_n` low mid-operation: the FSM aborts, `pend_rd` clears, and any in-flight `mem_rvld*` is ignored.

## Configuration
- Macro: `TS_MEM_INIT_EN`.
- Defined:
  - After reset, `INIT` writes 0 to every (x, y), x in 0..`DVS_WIDTH`-1, y in 0..`DVS_HEIGHT`-1, one word per cycle on port 1, y incrementing fastest.
  - Sweep length is `DVS_WIDTH*DVS_HEIGHT` = 89960 cycles.
  - `init_busy`=1 and no grants are issued during the sweep; requests are held off.
  - After the last write, go to `IDLE` and drop `init_busy`.
- Undefined: no `INIT` state, `init_busy` is tied to 0, and the memory contents after reset are whatever the memory holds.

## Structure
- Package `dnd_mem_pkg` holds:
  - the default parameter constants;
  - the `ts_word_t` packed struct `{ts, pol}`;
  - the FSM state enum.
- Sub-module `rr_arb2`: two-input round-robin arbiter with the `last_wr` flag and contention output. It is instantiated once.

## Test plan
- Only `rd_req` at (1,2)/(3,4), memory holding 3 and 7 at those pixels → `rd_gnt` at N+1, `rd_vld` at N+2, `rd_data1`=3, `rd_data2`=7.
- `wr_req` at (4,4) with `wr_ts`=100, `wr_pol`=1, then `rd_req` on (4,4) → `mem_wdata`=18'h00191; the read returns 18'h00191.
- `rd_req` and `wr_req` both held for 6 cycles from reset → grants alternate writer, reader, writer…; `conflict_cnt`=1 after the first tie.
- Reset asserted during `ISSUE_RD` → `rd_vld` never fires; all outputs are at reset values the next cycle.
- With `TS_MEM_INIT_EN`: `init_busy` high for 89960 cycles and every pixel reads 0. During the sweep, `rd_req` gets no grant; it is granted 1 cycle after `init_busy` falls.
- Hold `rd_req` and `wr_req` simultaneously for 70000 cycles → `conflict_cnt` saturates at 16'hFFFF.
